// File: rtl/seg_pkg.sv
// Shared constants for the signed scanned 7-segment display: active-low
// segment patterns ordered {dp,g,f,e,d,c,b,a}, the FSM state type and a sizing helper.
package seg_pkg;

    localparam logic [7:0] SEG_DIGIT [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'b1011_1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_COMMIT
    } state_e;

    // Number of decimal digits needed to print 2**e.
    function automatic int unsigned dec_digits_pow2(input int unsigned e);
        longint unsigned v;
        int unsigned     n;
        v = longint'(1) << e;
        n = 0;
        while (v != 0) begin
            v = v / 10;
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/signed_scan_display_if.sv
// Value/load/busy and display signals of signed_scan_display, bundled for hookup.
interface signed_scan_display_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 4
) ();
    logic [WIDTH-1:0]  value;
    logic              load;
    logic              busy;
    logic [7:0]        seg;
    logic [DIGITS-1:0] an;

    modport master (output value, output load, input busy, input seg, input an);
    modport slave  (input value, input load, output busy, output seg, output an);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift/add-3 step per clock for WIDTH
// clocks after start; done marks the cycle in which the final step is taken.
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      data,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0]    shift_q, shift_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d, adj;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                run_q, run_d;

    // done is combinational so the parent can leave CONV on the same edge the last step lands.
    assign done = run_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign bcd  = bcd_q;

    always_comb begin
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        adj     = bcd_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        if (start) begin
            shift_d = data;
            bcd_d   = '0;
            cnt_d   = '0;
            run_d   = 1'b1;
        end else if (run_q) begin
            bcd_d   = {adj[4*DIGITS-2:0], shift_q[WIDTH-1]};
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q + CNT_W'(1);
            if (done) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
        end
    end

endmodule

// File: rtl/signed_scan_display.sv
// Converts a signed value to decimal and shows it on DIGITS multiplexed
// active-low 7-segment digits with leading-zero blanking and a floating minus.
module signed_scan_display
    import seg_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  value,
    input  logic              load,
    output logic              busy,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] an
);
    localparam int IDX_W = $clog2(DIGITS);
    localparam int RW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int NEED  = int'(dec_digits_pow2(WIDTH - 1)) + 1;

    if (DIGITS < NEED) begin : g_digits_chk
        $error("signed_scan_display: DIGITS=%0d too small for WIDTH=%0d (need %0d)",
               DIGITS, WIDTH, NEED);
    end

    state_e              state_q, state_d;
    logic                sign_q, sign_d;
    logic [4*DIGITS-1:0] buf_q, buf_d;
    logic                neg_q, neg_d;
    logic [RW-1:0]       ref_q, ref_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    logic                start;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
    logic [WIDTH-1:0]    mag;

    // Negating the most negative value wraps to itself, which is the correct unsigned magnitude.
    assign mag = value[WIDTH-1] ? (~value + WIDTH'(1)) : value;

    bin2bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .data  (mag),
        .done  (done),
        .bcd   (bcd)
    );

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        buf_d   = buf_q;
        neg_d   = neg_q;
        start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    start   = 1'b1;
                    sign_d  = value[WIDTH-1];
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                if (done) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                buf_d   = bcd;
                neg_d   = sign_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy = (state_q != ST_IDLE);
    end

    always_comb begin
        ref_d = ref_q + RW'(1);
        idx_d = idx_q;
        if (ref_q == RW'(REFRESH_DIV - 1)) begin
            ref_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    logic [IDX_W-1:0] msd;
    logic             any_nz;
    logic [3:0]       nib;

    always_comb begin
        msd    = '0;
        any_nz = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (buf_q[4*i +: 4] != 4'd0) begin
                msd    = IDX_W'(i);
                any_nz = 1'b1;
            end
        end
        nib = buf_q[4*idx_q +: 4];
        seg = SEG_BLANK;
        if (!any_nz) begin
            if (idx_q == '0) begin
                seg = SEG_DIGIT[0];
            end
        end else if (idx_q <= msd) begin
            seg = (nib <= 4'd9) ? SEG_DIGIT[nib] : SEG_BLANK;
        end else if (neg_q &&
                     ((IDX_W+1)'(idx_q) == (IDX_W+1)'(msd) + (IDX_W+1)'(1))) begin
            seg = SEG_MINUS;
        end
        an = ~(DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sign_q  <= 1'b0;
            buf_q   <= '0;
            neg_q   <= 1'b0;
            ref_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            buf_q   <= buf_d;
            neg_q   <= neg_d;
            ref_q   <= ref_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: doc/signed_scan_display.md
SIGNED_SCAN_DISPLAY -- requirements
Module: signed_scan_display

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the two's-complement input width (legal range 2..16).
REQ-002 The block SHALL have parameter DIGITS, default 4, meaning the number of multiplexed 7-segment digits.
REQ-003 The block SHALL have parameter REFRESH_DIV, default 50000, meaning the clock cycles each digit stays enabled (legal range 1 or more).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port value, input, WIDTH bits: the signed two's-complement number to display.
REQ-007 The block SHALL have port load, input, 1 bit: request to convert and display value.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-009 The block SHALL have port seg, output, 8 bits: active-low segments, ordered {dp,g,f,e,d,c,b,a}.
REQ-010 The block SHALL have port an, output, DIGITS bits: active-low digit enables, where bit 0 is the rightmost digit.

Function
REQ-011 The FSM SHALL have three states:
- IDLE.
- CONV, lasting WIDTH cycles.
- COMMIT, lasting 1 cycle.
- busy SHALL be 1 in every state except IDLE.
REQ-012 In IDLE, a load sampled high SHALL capture the sign bit and the magnitude |value| as a (WIDTH)-bit unsigned number, then enter CONV.
- -2^(WIDTH-1) SHALL give magnitude 2^(WIDTH-1) with no overflow.
REQ-013 Any load arriving while busy=1 SHALL be ignored, with no queuing.
REQ-014 CONV SHALL perform one double-dabble shift/add-3 step per cycle on a BCD register of DIGITS nibbles.
REQ-015 COMMIT SHALL write the BCD result and the sign into the display buffer, then return to IDLE.
- busy SHALL fall, and the new content SHALL become visible, at the edge WIDTH+1 cycles after the load edge.
REQ-016 Leading zeros SHALL be blanked (seg=8'hFF). The value 0 SHALL show a single "0" on digit 0.
REQ-017 A negative value SHALL show minus (8'b10111111) on the digit immediately left of the most-significant nonzero digit. Zero SHALL never show a minus.
REQ-018 Elaboration SHALL fail if DIGITS is smaller than (decimal digit count of 2^(WIDTH-1)) + 1.
REQ-019 Scanning: a refresh counter SHALL count 0..REFRESH_DIV-1. On wrap, the digit index SHALL advance 0,1,..,DIGITS-1,0.
- an SHALL be all ones except a 0 at the current index.
- seg SHALL carry that digit's pattern in the same cycle.
REQ-020 Scanning SHALL run continuously and SHALL be independent of the conversion state. The buffer SHALL change only in COMMIT.
REQ-021 dp SHALL always be 1 (off).

Reset
REQ-022 While rst_n=0, the block SHALL asynchronously hold:
- state IDLE, busy=0;
- refresh counter 0, digit index 0;
- display buffer = positive zero;
- an = {DIGITS-1{1},0}, seg = 8'hC0.
REQ-023 Reset during CONV or COMMIT SHALL abort the conversion. The result SHALL be discarded, and the block SHALL show "0" after release.
REQ-024 The first load SHALL be honoured on the first rising edge after rst_n is released.

Structure
REQ-025 Package seg_pkg SHALL hold:
- the SEG_DIGIT[0..9] patterns;
- SEG_BLANK (8'hFF) and SEG_MINUS (8'b10111111);
- the FSM state enum.
REQ-026 The converter SHALL be the sub-module bin2bcd_seq (parameters WIDTH, DIGITS; ports start, data, done, bcd).
- Sign handling, the display buffer and the scanner SHALL stay in the top module.

Verification
Use WIDTH=8, DIGITS=4, REFRESH_DIV=4.
REQ-027 Scenario 1: hold rst_n=0, then release -> busy=0, an=4'b1110, seg=8'hC0; an cycles 1110,1101,1011,0111 every 4 clocks.
REQ-028 Scenario 2: load value=8'h80 (-128) -> busy high for exactly 9 cycles. Digits 3..0 = minus, "1", "2", "8".
REQ-029 Scenario 3: load 8'hF9 (-7) -> digits 3..0 = blank, blank, minus, "7". Then load 8'h05 -> blank, blank, blank, "5".
REQ-030 Scenario 4: load 8'h7F, then pulse load with 8'h01 while busy -> display shows "127" and the second request is discarded.
REQ-031 Scenario 5: load 8'h64, then assert rst_n=0 on the 4th CONV cycle -> after release, busy=0 and the display shows "0".
REQ-032 Scenario 6: load 8'h00 -> only digit 0 shows "0", with no minus. Elaborating with WIDTH=16, DIGITS=5 -> elaboration error.
